// File: rtl/emisor_partidas.sv
// Game-code emitter: plays a latched pattern of up to five 2-bit game codes
// into the match state machine as J1G/J2G pulses, stopping early on match end or error.
module emisor_partidas (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Start,
  input  logic [9:0] Patron,
  input  logic [2:0] N_Juegos,
  input  logic       V_J1G3,
  input  logic       V_J2G3,
  input  logic       ERR_11,
  output logic       J1G,
  output logic       J2G,
  output logic       Ocupado,
  output logic       Hecho,
  output logic       Corte,
  output logic [2:0] Emitidos
);

  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    EMITE  = 2'd1,
    PAUSA  = 2'd2,
    FIN    = 2'd3
  } estado_t;

  estado_t    estado_q, estado_d;
  logic [9:0] patron_q, patron_d;
  logic [2:0] total_q, total_d;
  logic [2:0] emitidos_q, emitidos_d;
  logic       j1g_q, j1g_d;
  logic       j2g_q, j2g_d;
  logic       ocupado_q, ocupado_d;
  logic       hecho_q, hecho_d;
  logic       corte_q, corte_d;
  logic [1:0] codigo_s;

  // Emitidos doubles as the game index: both start at 0 and advance together.
  always_comb begin
    case (emitidos_q)
      3'd0:    codigo_s = patron_q[1:0];
      3'd1:    codigo_s = patron_q[3:2];
      3'd2:    codigo_s = patron_q[5:4];
      3'd3:    codigo_s = patron_q[7:6];
      3'd4:    codigo_s = patron_q[9:8];
      default: codigo_s = 2'b00;
    endcase
  end

  // Next-state and next-output logic for the sequencer.
  always_comb begin
    estado_d   = estado_q;
    patron_d   = patron_q;
    total_d    = total_q;
    emitidos_d = emitidos_q;
    ocupado_d  = ocupado_q;
    corte_d    = corte_q;
    j1g_d      = 1'b0;
    j2g_d      = 1'b0;
    hecho_d    = 1'b0;
    case (estado_q)
      REPOSO: begin
        if (Start) begin
          patron_d   = Patron;
          total_d    = (N_Juegos > 3'd5) ? 3'd5 : N_Juegos;
          emitidos_d = 3'd0;
          corte_d    = 1'b0;
          ocupado_d  = 1'b1;
          estado_d   = (total_d != 3'd0) ? EMITE : FIN;
        end else begin
          estado_d = REPOSO;
        end
      end
      EMITE: begin
        j1g_d    = codigo_s[0];
        j2g_d    = codigo_s[1];
        estado_d = PAUSA;
        if (emitidos_q < 3'd5) begin
          emitidos_d = emitidos_q + 3'd1;
        end else begin
          emitidos_d = emitidos_q;
        end
      end
      PAUSA: begin
        if (V_J1G3 || V_J2G3 || ERR_11) begin
          corte_d  = 1'b1;
          estado_d = FIN;
        end else if (emitidos_q == total_q) begin
          estado_d = FIN;
        end else begin
          estado_d = EMITE;
        end
      end
      FIN: begin
        hecho_d   = 1'b1;
        ocupado_d = 1'b0;
        estado_d  = REPOSO;
      end
      default: begin
        ocupado_d = 1'b0;
        estado_d  = REPOSO;
      end
    endcase
  end

  // State and registered outputs; Reset overrides everything.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      estado_q   <= REPOSO;
      patron_q   <= 10'd0;
      total_q    <= 3'd0;
      emitidos_q <= 3'd0;
      j1g_q      <= 1'b0;
      j2g_q      <= 1'b0;
      ocupado_q  <= 1'b0;
      hecho_q    <= 1'b0;
      corte_q    <= 1'b0;
    end else begin
      estado_q   <= estado_d;
      patron_q   <= patron_d;
      total_q    <= total_d;
      emitidos_q <= emitidos_d;
      j1g_q      <= j1g_d;
      j2g_q      <= j2g_d;
      ocupado_q  <= ocupado_d;
      hecho_q    <= hecho_d;
      corte_q    <= corte_d;
    end
  end

  assign J1G      = j1g_q;
  assign J2G      = j2g_q;
  assign Ocupado  = ocupado_q;
  assign Hecho    = hecho_q;
  assign Corte    = corte_q;
  assign Emitidos = emitidos_q;

endmodule

// File: tb/tb_emisor_partidas.sv
// Randomized bench for emisor_partidas: a per-sequence reference model predicts
// every output cycle by cycle from the pattern, count and stop-input schedule.
module tb_emisor_partidas;
  logic       Clk = 1'b0;
  logic       Reset, Start, V_J1G3, V_J2G3, ERR_11;
  logic [9:0] Patron;
  logic [2:0] N_Juegos;
  logic       J1G, J2G, Ocupado, Hecho, Corte;
  logic [2:0] Emitidos;

  int checks = 0;
  int failures = 0;

  logic [2:0] stop_vec [0:15];  // {ERR_11,V_J2G3,V_J1G3} driven before edge e after Start
  logic [7:0] exp_out [0:15];   // {J1G,J2G,Hecho,Ocupado,Corte,Emitidos} after edge c
  int         hecho_c;
  logic [7:0] held;

  emisor_partidas dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Patron(Patron), .N_Juegos(N_Juegos),
    .V_J1G3(V_J1G3), .V_J2G3(V_J2G3), .ERR_11(ERR_11),
    .J1G(J1G), .J2G(J2G), .Ocupado(Ocupado), .Hecho(Hecho), .Corte(Corte), .Emitidos(Emitidos)
  );

  always #5 Clk = ~Clk;

  // Game i shows on cycle 2i+1, its pause decision is at edge 2i+2, Hecho one cycle after the end.
  task automatic model(input logic [9:0] pat, input logic [2:0] n);
    int  n_eff, emitted, corte_from, code, emit;
    logic j1 [0:15];
    logic j2 [0:15];
    n_eff = (n > 3'd5) ? 5 : int'(n);
    emitted = 0;
    corte_from = -1;
    hecho_c = 1;
    for (int c = 0; c < 16; c++) begin
      j1[c] = 1'b0;
      j2[c] = 1'b0;
    end
    for (int i = 0; i < n_eff; i++) begin
      code = (int'(pat) >> (2 * i)) & 3;
      j1[2*i+1] = (code & 1) != 0;
      j2[2*i+1] = (code & 2) != 0;
      emitted = i + 1;
      hecho_c = 2 * i + 3;
      if (stop_vec[2*i+2] != 3'd0) begin
        corte_from = 2 * i + 2;
        break;
      end
    end
    for (int c = 0; c < 16; c++) begin
      emit = (c == 0) ? 0 : (((c + 1) / 2 < emitted) ? (c + 1) / 2 : emitted);
      exp_out[c] = {j1[c], j2[c], 1'(c == hecho_c), 1'(c < hecho_c),
                    1'(corte_from >= 0 && c >= corte_from), 3'(emit)};
    end
  endtask

  task automatic clear_stops();
    for (int e = 0; e < 16; e++) stop_vec[e] = 3'd0;
  endtask

  task automatic random_stops();
    for (int e = 0; e < 16; e++)
      stop_vec[e] = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
  endtask

  // One full sequence with Start/Patron/N_Juegos noise injected while busy.
  task automatic run_seq(input logic [9:0] pat, input logic [2:0] n);
    model(pat, n);
    @(negedge Clk);
    Start = 1'b1;
    Patron = pat;
    N_Juegos = n;
    {ERR_11, V_J2G3, V_J1G3} = stop_vec[0];
    for (int c = 0; c <= hecho_c + 1; c++) begin
      @(negedge Clk);
      checks++;
      if ({J1G, J2G, Hecho, Ocupado, Corte, Emitidos} !== exp_out[c]) begin
        failures++;
        $display("FAIL seq cycle=%0d pat=%b n=%0d got=%b want=%b", c, pat, n,
                 {J1G, J2G, Hecho, Ocupado, Corte, Emitidos}, exp_out[c]);
      end
      Start = (c + 1 <= hecho_c) ? 1'($urandom_range(0, 1)) : 1'b0;
      Patron = 10'($urandom);
      N_Juegos = 3'($urandom);
      {ERR_11, V_J2G3, V_J1G3} = stop_vec[c+1];
    end
    held = exp_out[hecho_c+1];
    {ERR_11, V_J2G3, V_J1G3} = 3'd0;
  endtask

  task automatic idle(input int nc);
    for (int i = 0; i < nc; i++) begin
      @(negedge Clk);
      checks++;
      if ({J1G, J2G, Hecho, Ocupado, Corte, Emitidos} !== held) begin
        failures++;
        $display("FAIL idle_hold got=%b want=%b", {J1G, J2G, Hecho, Ocupado, Corte, Emitidos}, held);
      end
      Start = 1'b0;
      Patron = 10'($urandom);
      N_Juegos = 3'($urandom);
      {ERR_11, V_J2G3, V_J1G3} = 3'($urandom);
    end
    {ERR_11, V_J2G3, V_J1G3} = 3'd0;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Start = 1'b1;
    Patron = 10'h3FF;
    N_Juegos = 3'd5;
    {ERR_11, V_J2G3, V_J1G3} = 3'd0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    checks++;
    if ({J1G, J2G, Hecho, Ocupado, Corte, Emitidos} !== 8'd0) begin
      failures++;
      $display("FAIL reset_state got=%b want=%b", {J1G, J2G, Hecho, Ocupado, Corte, Emitidos}, 8'd0);
    end
    Reset = 1'b0;
    Start = 1'b0;
    held = 8'd0;
    idle(2);
  endtask

  task automatic test_stop_on_match();
    clear_stops();
    for (int e = 6; e < 16; e++) stop_vec[e] = 3'b001;
    run_seq(10'b00_01_01_01_01, 3'd5);
    checks++;
    if ({Corte, Emitidos} !== {1'b1, 3'd3}) begin
      failures++;
      $display("FAIL match_stop corte_emit got=%b want=%b", {Corte, Emitidos}, {1'b1, 3'd3});
    end
    idle(2);
  endtask

  task automatic test_directed();
    clear_stops();
    run_seq(10'b00_00_10_10_10, 3'd3);
    idle(1);
    clear_stops();
    run_seq(10'b01_10_10_01_01, 3'd7);
    checks++;
    if ({Corte, Emitidos} !== {1'b0, 3'd5}) begin
      failures++;
      $display("FAIL clamp corte_emit got=%b want=%b", {Corte, Emitidos}, {1'b0, 3'd5});
    end
    idle(1);
    clear_stops();
    for (int e = 2; e < 16; e++) stop_vec[e] = 3'b100;
    run_seq({8'($urandom), 2'b11}, 3'd5);
    idle(1);
    random_stops();
    run_seq(10'($urandom), 3'd0);
    idle(2);
  endtask

  task automatic test_reset_mid();
    @(negedge Clk);
    Start = 1'b1;
    Patron = 10'b01_01_10_01_10;
    N_Juegos = 3'd5;
    repeat (4) begin
      @(negedge Clk);
      Start = 1'b0;
    end
    Reset = 1'b1;
    Start = 1'b1;
    @(negedge Clk);
    checks++;
    if ({J1G, J2G, Hecho, Ocupado, Corte, Emitidos} !== 8'd0) begin
      failures++;
      $display("FAIL reset_mid got=%b want=%b", {J1G, J2G, Hecho, Ocupado, Corte, Emitidos}, 8'd0);
    end
    Reset = 1'b0;
    Start = 1'b0;
    held = 8'd0;
    idle(3);
    clear_stops();
    run_seq(10'($urandom), 3'd5);
    idle(1);
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      random_stops();
      run_seq(10'($urandom), 3'($urandom));
      idle($urandom_range(0, 2));
    end
  endtask

  initial begin
    test_reset();
    test_stop_on_match();
    test_directed();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
